button_conditioner: RTL

Input-conditioning stage that sits between the raw push-buttons on `ui_in[3:0]` and the animation/speed controller. Each button is synchronised, debounced and turned into a clean level, a one-cycle press pulse and a one-cycle release pulse. Press pulses optionally auto-repeat while a button is held. The controller steps the animation or speed exactly once per `btn_press` pulse, never on a level.

---
 rtl/seg_fun_pkg.sv | 22 ++
 rtl/btn_channel.sv | 131 +++++++++++++
 rtl/button_conditioner.sv | 37 +++
 3 files changed

// File: rtl/seg_fun_pkg.sv
// Shared definitions for the button conditioning path: the per-channel FSM
// encoding, default timing constants and a counter-width helper.
package seg_fun_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    ARMING    = 2'b01,
    HELD      = 2'b10,
    RELEASING = 2'b11
  } btn_state_e;

  // Defaults assume a 10 MHz system clock.
  localparam int DEBOUNCE_CYCLES = 512;
  localparam int REPEAT_DELAY    = 5_000_000;
  localparam int REPEAT_PERIOD   = 2_000_000;

  // Counter width able to hold n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: 2-FF synchroniser, debounce FSM with registered
// level/press/release, and an auto-repeat counter that runs while held.
module btn_channel
  import seg_fun_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = seg_fun_pkg::DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = seg_fun_pkg::REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = seg_fun_pkg::REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  input  logic repeat_en,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release
);

  localparam int DW = cnt_w(DEBOUNCE_CYCLES);
  localparam int RW = cnt_w(REPEAT_DELAY);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);

  logic [1:0]    sync_ff;
  logic          sync;
  btn_state_e    state, state_n;
  logic [DW-1:0] cnt, cnt_n;
  logic [RW-1:0] rcnt, rcnt_n;
  logic          rphase, rphase_n;   // 0: waiting initial delay, 1: periodic
  logic          press_n, release_n, rpt_hit;

  assign sync = sync_ff[1];

  // Two-stage synchroniser for the asynchronous button input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_ff <= '0;
    else        sync_ff <= {sync_ff[0], btn_raw};
  end

  // State, counters and registered pulse outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      rcnt        <= '0;
      rphase      <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      rcnt        <= rcnt_n;
      rphase      <= rphase_n;
      btn_press   <= press_n;
      btn_release <= release_n;
    end
  end

  // Level is a pure function of the state register, so still registered
  assign btn_level = (state == HELD) || (state == RELEASING);

  // Next-state, debounce counting and repeat cadence
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    rcnt_n    = rcnt;
    rphase_n  = rphase;
    release_n = 1'b0;
    rpt_hit   = 1'b0;

    // Repeat counter keeps running through a rejected release glitch
    if (state == HELD || state == RELEASING) begin
      rpt_hit = (rcnt == (rphase ? RP_LAST : RD_LAST));
      if (rpt_hit) begin
        rcnt_n   = '0;
        rphase_n = 1'b1;
      end else begin
        rcnt_n = rcnt + RW'(1);
      end
    end
    press_n = rpt_hit && repeat_en;

    case (state)
      IDLE: begin
        if (sync) begin
          state_n = ARMING;
          cnt_n   = DW'(1);
        end
      end
      ARMING: begin
        if (!sync) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt == DB_LAST) begin
          state_n  = HELD;
          cnt_n    = '0;
          press_n  = 1'b1;
          rcnt_n   = '0;
          rphase_n = 1'b0;
        end else begin
          cnt_n = cnt + DW'(1);
        end
      end
      HELD: begin
        if (!sync) begin
          state_n = RELEASING;
          cnt_n   = DW'(1);
        end
      end
      RELEASING: begin
        if (sync) begin
          state_n = HELD;
          cnt_n   = '0;
        end else if (cnt == DB_LAST) begin
          // Release wins over a coincident repeat event
          state_n   = IDLE;
          cnt_n     = '0;
          rcnt_n    = '0;
          rphase_n  = 1'b0;
          press_n   = 1'b0;
          release_n = 1'b1;
        end else begin
          cnt_n = cnt + DW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: rtl/button_conditioner.sv
// Conditions N_BTN raw push-buttons into debounced levels plus press/release
// pulses with optional auto-repeat; channels are fully independent.
module button_conditioner
  import seg_fun_pkg::*;
#(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = seg_fun_pkg::DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = seg_fun_pkg::REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = seg_fun_pkg::REPEAT_PERIOD
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic [N_BTN-1:0] repeat_en,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);

  // One independent conditioning channel per button
  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .btn_raw    (btn_raw[i]),
      .repeat_en  (repeat_en[i]),
      .btn_level  (btn_level[i]),
      .btn_press  (btn_press[i]),
      .btn_release(btn_release[i])
    );
  end

endmodule
